// File: rtl/dsp_slot_scheduler.sv
// dsp_slot_scheduler
//
// Fixed 64-step timing sequencer for an 8-voice sample-synthesis DSP.
// Each enabled clock moves the schedule forward one step. The current step
// decides which unit owns the sample RAM, when each voice begins its decode
// window, and when the DAC latches a finished sample.
//
// Ports
//   clock, reset    system clock; synchronous active-high reset
//   enable          advance permission; the schedule holds while low
//   kon_in/kon_write    key-on mask and its one-cycle write strobe
//   koff_in/koff_write  key-off mask and its one-cycle write strobe
//   aux_req         level request from the auxiliary RAM client
//   major_step      current schedule step, 0..63
//   voice_advance   one-hot pulse that starts voice i's decode window
//   voice_select    voice that owns the RAM address mux
//   ram_owner       0=voice, 1=echo, 2=dir, 3=aux/idle
//   dir_voice       voice whose directory entry is read this sample
//   voice_keyon     key-on pulse, aligned with that voice's voice_advance
//   voice_keyoff    key-off pulse, aligned with that voice's voice_advance
//   sample_strobe   pulse at step 63 that latches the DAC output
//   aux_grant       RAM handed to the auxiliary client this cycle

module dsp_slot_scheduler #(
  parameter int N_VOICES = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_VOICES-1:0] kon_in,
  input  logic                kon_write,
  input  logic [N_VOICES-1:0] koff_in,
  input  logic                koff_write,
  input  logic                aux_req,
  output logic [5:0]          major_step,
  output logic [N_VOICES-1:0] voice_advance,
  output logic [2:0]          voice_select,
  output logic [1:0]          ram_owner,
  output logic [2:0]          dir_voice,
  output logic [N_VOICES-1:0] voice_keyon,
  output logic [N_VOICES-1:0] voice_keyoff,
  output logic                sample_strobe,
  output logic                aux_grant
);

  typedef enum logic [1:0] {
    OWN_VOICE = 2'd0,
    OWN_ECHO  = 2'd1,
    OWN_DIR   = 2'd2,
    OWN_AUX   = 2'd3
  } owner_t;

  owner_t              owner;
  logic                run;
  logic [5:0]          step_plus2;
  logic [N_VOICES-1:0] kon_pend;
  logic [N_VOICES-1:0] koff_pend;

  // Pulses are gated with reset as well as enable, so that the cycle in which
  // reset is sampled emits nothing, even part-way through a sample.
  assign run        = enable & ~reset;
  assign step_plus2 = major_step + 6'd2;

  // Voice i starts at step 4*i-2 (mod 64). Adding 62 and truncating to
  // 6 bits gives the same wrap without any signed arithmetic.
  always_comb begin
    voice_advance = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      if (major_step == 6'(4 * i + 62)) begin
        voice_advance[i] = run;
      end
    end
  end

  // RAM ownership by step. The voice window wraps through step 0, so it runs
  // from 62 up to 29. The +2 offset lines each voice's 4-step RAM slot up
  // with its advance pulse.
  always_comb begin
    owner = OWN_AUX;
    if (major_step >= 6'd62 || major_step <= 6'd29) begin
      owner = OWN_VOICE;
    end else if (major_step >= 6'd33 && major_step <= 6'd40) begin
      owner = OWN_ECHO;
    end else if (major_step >= 6'd41 && major_step <= 6'd46) begin
      owner = OWN_DIR;
    end
  end

  assign ram_owner     = owner;
  assign voice_select  = (owner == OWN_VOICE) ? step_plus2[4:2] : 3'd0;
  assign aux_grant     = aux_req & run & (owner == OWN_AUX);
  assign sample_strobe = run & (major_step == 6'd63);

  // Key events come only from the pending registers, so a write can never
  // reach a pulse output in the cycle it arrives.
  assign voice_keyon  = voice_advance & kon_pend;
  assign voice_keyoff = voice_advance & koff_pend & ~kon_pend;

  // Schedule state and pending key masks. The pending update clears the
  // consumed voice first and then applies the new write. A write that lands
  // on the consume cycle therefore survives and fires one sample later.
  always_ff @(posedge clock) begin
    if (reset) begin
      major_step <= 6'd62;
      dir_voice  <= 3'd0;
      kon_pend   <= '0;
      koff_pend  <= '0;
    end else begin
      if (enable) begin
        major_step <= major_step + 6'd1;
      end
      if (sample_strobe) begin
        dir_voice <= dir_voice + 3'd1;
      end
      kon_pend  <= (kon_pend  & ~voice_advance) | (kon_write  ? kon_in  : '0);
      koff_pend <= (koff_pend & ~voice_advance) | (koff_write ? koff_in : '0);
    end
  end

endmodule

// File: tb/tb_dsp_slot_scheduler.sv
// tb_dsp_slot_scheduler
//
// Directed and random stimulus for dsp_slot_scheduler. A behavioural model
// built from the schedule rules (step ranges, start steps, pending masks)
// predicts every output on every cycle.

module tb_dsp_slot_scheduler;

  logic       clock = 1'b0;
  logic       reset, enable, kon_write, koff_write, aux_req;
  logic [7:0] kon_in, koff_in;
  logic [5:0] major_step;
  logic [7:0] voice_advance, voice_keyon, voice_keyoff;
  logic [2:0] voice_select, dir_voice;
  logic [1:0] ram_owner;
  logic       sample_strobe, aux_grant;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int       m_step;
  int       m_dir;
  bit [7:0] m_kon, m_koff;
  bit       m_valid = 1'b0;

  // Observation tallies used by the scenario checks
  int       cyc;
  int       grant_seen, keyon_seen, keyoff_seen, adv6_seen;
  bit [7:0] obs_adv;
  bit       obs_strobe;

  dsp_slot_scheduler #(.N_VOICES(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .kon_in        (kon_in),
    .kon_write     (kon_write),
    .koff_in       (koff_in),
    .koff_write    (koff_write),
    .aux_req       (aux_req),
    .major_step    (major_step),
    .voice_advance (voice_advance),
    .voice_select  (voice_select),
    .ram_owner     (ram_owner),
    .dir_voice     (dir_voice),
    .voice_keyon   (voice_keyon),
    .voice_keyoff  (voice_keyoff),
    .sample_strobe (sample_strobe),
    .aux_grant     (aux_grant)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Voice whose decode window starts at step s, or -1 for none.
  function automatic int voice_at(input int s);
    int v;
    if (s % 4 != 2) return -1;
    v = ((s + 2) % 64) / 4;
    return (v < 8) ? v : -1;
  endfunction

  function automatic int owner_at(input int s);
    if (s >= 62 || s <= 29) return 0;
    if (s >= 33 && s <= 40) return 1;
    if (s >= 41 && s <= 46) return 2;
    return 3;
  endfunction

  function automatic bit [7:0] exp_adv(input bit en, input bit rst);
    bit [7:0] a;
    int v;
    a = 8'h00;
    v = voice_at(m_step);
    if (m_valid && !rst && en && v >= 0) a[v] = 1'b1;
    return a;
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic checkOutput(input bit en, input bit rst, input bit aux);
    bit [7:0] a;
    int       own;
    a   = exp_adv(en, rst);
    own = owner_at(m_step);
    if (m_valid) begin
      chk("major_step", 32'(major_step), 32'(m_step));
      chk("ram_owner", 32'(ram_owner), 32'(own));
      chk("voice_select", 32'(voice_select), (own == 0) ? 32'(((m_step + 2) % 64) / 4) : 32'd0);
      chk("dir_voice", 32'(dir_voice), 32'(m_dir));
    end
    chk("voice_advance", 32'(voice_advance), 32'(a));
    chk("voice_keyon", 32'(voice_keyon), 32'(a & m_kon));
    chk("voice_keyoff", 32'(voice_keyoff), 32'(a & m_koff & ~m_kon));
    chk("sample_strobe", 32'(sample_strobe), 32'(m_valid && !rst && en && m_step == 63));
    chk("aux_grant", 32'(aux_grant), 32'(m_valid && !rst && en && aux && own == 3));
    obs_adv    = voice_advance;
    obs_strobe = sample_strobe;
    if (aux_grant === 1'b1) grant_seen++;
    if (voice_advance[6] === 1'b1) adv6_seen++;
    keyon_seen  += $countones(voice_keyon);
    keyoff_seen += $countones(voice_keyoff);
  endtask

  // Drive one cycle of inputs, check outputs on the falling edge, then step
  // the model in step with the rising edge.
  task automatic applyStimulus(input bit en, input bit rst, input bit [7:0] kon, input bit konw,
                               input bit [7:0] koff, input bit koffw, input bit aux);
    bit [7:0] a;
    bit       strobe;
    reset      = rst;
    enable     = en;
    kon_in     = kon;
    kon_write  = konw;
    koff_in    = koff;
    koff_write = koffw;
    aux_req    = aux;
    @(negedge clock);
    checkOutput(en, rst, aux);
    a      = exp_adv(en, rst);
    strobe = m_valid && !rst && en && m_step == 63;
    if (rst) begin
      m_step  = 62;
      m_dir   = 0;
      m_kon   = 8'h00;
      m_koff  = 8'h00;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (strobe) m_dir = (m_dir + 1) % 8;
      m_kon  = (m_kon & ~a)  | (konw  ? kon  : 8'h00);
      m_koff = (m_koff & ~a) | (koffw ? koff : 8'h00);
      if (en) m_step = (m_step + 1) % 64;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  // Advance with enable held until the schedule reaches the target step.
  task automatic runTo(input int target);
    int n;
    n = 0;
    while (m_step != target && n < 70) begin
      idle(1);
      n++;
    end
    chk("runTo_step", 32'(major_step), 32'(target));
  endtask

  initial begin
    int first_strobe, adv7_cyc, adv1_cyc;
    bit en, rst, kw, fw, ax;
    reset = 1'b1; enable = 1'b0; kon_in = '0; koff_in = '0;
    kon_write = 1'b0; koff_write = 1'b0; aux_req = 1'b0;
    @(posedge clock);
    #1;

    // Reset with strobe writes that must be ignored
    $display("[TB] reset and free-running schedule");
    applyStimulus(1, 1, 8'hFF, 1, 8'hFF, 1, 1);
    applyStimulus(1, 1, 8'hFF, 1, 8'hFF, 1, 1);
    chk("reset_step", 32'(major_step), 32'd62);
    chk("reset_dir", 32'(dir_voice), 32'd0);

    // Free run after reset: advance/strobe timing
    cyc = 0; first_strobe = -1; adv7_cyc = -1; adv1_cyc = -1; keyon_seen = 0;
    for (int i = 0; i < 130; i++) begin
      applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 0);
      if (obs_strobe && first_strobe < 0) first_strobe = i;
      if (obs_adv == 8'h80 && adv7_cyc < 0) adv7_cyc = i;
      if (obs_adv == 8'h02 && adv1_cyc < 0) adv1_cyc = i;
    end
    chk("first_strobe_cycle", 32'(first_strobe), 32'd1);
    chk("adv1_cycle", 32'(adv1_cyc), 32'd4);
    chk("adv7_cycle", 32'(adv7_cyc), 32'd28);
    chk("no_keyon_after_reset_writes", 32'(keyon_seen), 32'd0);

    // Key-on 0x05 written at step 10
    $display("[TB] key-on mask 0x05");
    runTo(10);
    keyon_seen = 0;
    applyStimulus(1, 0, 8'h05, 1, 8'h00, 0, 0);
    idle(70);
    chk("kon05_pulses", 32'(keyon_seen), 32'd2);

    // Key-on and key-off for the same voice: key-on wins
    $display("[TB] key-on beats key-off");
    runTo(40);
    keyon_seen = 0; keyoff_seen = 0;
    applyStimulus(1, 0, 8'h08, 1, 8'h08, 1, 0);
    idle(100);
    chk("kon_koff_keyon", 32'(keyon_seen), 32'd1);
    chk("kon_koff_keyoff", 32'(keyoff_seen), 32'd0);

    // Key-off alone
    runTo(50);
    keyoff_seen = 0;
    applyStimulus(1, 0, 8'h00, 0, 8'h21, 1, 0);
    idle(70);
    chk("koff_pulses", 32'(keyoff_seen), 32'd2);

    // Aux requester held for one sample
    $display("[TB] aux requester");
    grant_seen = 0;
    for (int i = 0; i < 64; i++) applyStimulus(1, 0, 8'h00, 0, 8'h00, 0, 1);
    chk("aux_grants_per_sample", 32'(grant_seen), 32'd18);

    // Enable dropped for 5 cycles at step 20, with a write while frozen
    $display("[TB] enable freeze");
    runTo(20);
    keyon_seen = 0; adv6_seen = 0;
    applyStimulus(0, 0, 8'h40, 1, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 8'h00, 0, 8'h00, 0, 1);
    chk("freeze_step", 32'(major_step), 32'd20);
    idle(1);
    chk("resume_step", 32'(major_step), 32'd21);
    idle(63);
    chk("adv6_once", 32'(adv6_seen), 32'd1);
    chk("kon6_once", 32'(keyon_seen), 32'd1);

    // Write landing on the consume cycle stays pending for one more sample
    $display("[TB] write on consume cycle");
    runTo(10);
    applyStimulus(1, 0, 8'h10, 1, 8'h00, 0, 0);
    runTo(14);
    keyon_seen = 0;
    applyStimulus(1, 0, 8'h10, 1, 8'h00, 0, 0);
    chk("consume_first", 32'(keyon_seen), 32'd1);
    idle(64);
    chk("consume_refire", 32'(keyon_seen), 32'd2);

    // Reset mid-sample discards pending key-ons
    $display("[TB] reset mid-sample");
    applyStimulus(1, 0, 8'hFF, 1, 8'h00, 0, 0);
    runTo(45);
    keyon_seen = 0;
    applyStimulus(1, 1, 8'h00, 0, 8'h00, 0, 0);
    chk("midreset_step", 32'(major_step), 32'd62);
    chk("midreset_dir", 32'(dir_voice), 32'd0);
    idle(2);
    chk("dir_after_strobe", 32'(dir_voice), 32'd1);
    idle(64);
    chk("midreset_no_keyon", 32'(keyon_seen), 32'd0);

    // Random traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      kw  = ($urandom_range(0, 9) == 0);
      fw  = ($urandom_range(0, 9) == 0);
      ax  = $urandom_range(0, 1);
      applyStimulus(en, rst, 8'($urandom), kw, 8'($urandom), fw, ax);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
